drop_controller: RTL

Parametrised column-drop game controller for the board display path. It tracks per-column fill heights for a configurable NUM_COLS × NUM_ROWS board and rotates among NUM_PLAYERS players. It issues one board-memory write per accepted drop and hands each placed coin to an external win checker through a req/done handshake. It sits between the column-select/enter user inputs and the board RAM and win-check logic, and latches game-over state until a new game is started.

---
 rtl/drop_controller.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/drop_controller.sv
// drop_controller: column-drop game controller.
// Tracks per-column fill heights, rotates players, emits one board RAM write
// per accepted drop and hands the placed coin to an external win checker.
// Optional feature macro: DROP_DRAW_EN. When it is defined, a full board with
// no winner ends the game as a draw. When it is not defined, draw is tied to 0.
module drop_controller #(
  parameter int NUM_COLS    = 7,
  parameter int NUM_ROWS    = 6,
  parameter int NUM_PLAYERS = 2,
  localparam int CW = $clog2(NUM_COLS),
  localparam int AW = $clog2(NUM_COLS*NUM_ROWS),
  localparam int PW = $clog2(NUM_PLAYERS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic          enter,
  input  logic [CW-1:0] col_sel,
  input  logic          chk_done,
  input  logic          chk_win,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [PW-1:0] wdata,
  output logic          chk_req,
  output logic [AW-1:0] chk_addr,
  output logic [PW-1:0] player,
  output logic [PW-1:0] winner,
  output logic          game_over,
  output logic          draw,
  output logic          reject,
  output logic          busy
);

  localparam int HW    = $clog2(NUM_ROWS+1);
  localparam int CELLS = NUM_COLS*NUM_ROWS;
  localparam int MW    = $clog2(CELLS+1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_CHECK   = 3'd2,
    S_ADVANCE = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          enter_q;
  logic          enter_edge;
  logic [HW-1:0] height_q [NUM_COLS];
  logic [HW-1:0] height_sel;
  logic          col_ok;
  logic          col_full;
  logic [CW-1:0] col_q, col_d;
  logic [HW-1:0] row_q, row_d;
  logic [PW-1:0] player_q, player_d;
  logic [PW-1:0] winner_q, winner_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [PW-1:0] wdata_q, wdata_d;
  logic          chk_req_q, chk_req_d;
  logic [AW-1:0] chk_addr_q, chk_addr_d;
  logic          reject_q, reject_d;
  logic          busy_q, busy_d;
  logic          game_over_q, game_over_d;

`ifdef DROP_DRAW_EN
  logic [MW-1:0] move_q;
  logic          draw_q, draw_d;
  logic          board_full;
`endif

  // Board address of a cell; row 0 is the bottom row.
  function automatic logic [AW-1:0] cell_addr(input logic [HW-1:0] r,
                                              input logic [CW-1:0] c);
    return AW'(r) * AW'(NUM_COLS) + AW'(c);
  endfunction

  assign enter_edge = enter & ~enter_q;

  // Look up the selected column's height; out-of-range columns match nothing.
  always_comb begin
    height_sel = '0;
    col_ok     = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_sel == CW'(c)) begin
        height_sel = height_q[c];
        col_ok     = 1'b1;
      end
    end
  end

  assign col_full = (height_sel == HW'(NUM_ROWS));

  // Next-state and registered-output computation; new_game overrides all.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    player_d = player_q;
    winner_d = winner_q;
    reject_d = 1'b0;
`ifdef DROP_DRAW_EN
    draw_d   = draw_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enter_edge) begin
          if (!col_ok || col_full) begin
            reject_d = 1'b1;
          end else begin
            col_d   = col_sel;
            row_d   = height_sel;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (chk_done) begin
          if (chk_win) begin
            winner_d = player_q + 1'b1;
            state_d  = S_OVER;
`ifdef DROP_DRAW_EN
          end else if (board_full) begin
            draw_d  = 1'b1;
            state_d = S_OVER;
`endif
          end else begin
            state_d = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        player_d = (player_q == PW'(NUM_PLAYERS-1)) ? '0 : player_q + 1'b1;
        state_d  = S_IDLE;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (new_game) begin
      state_d  = S_IDLE;
      player_d = '0;
      winner_d = '0;
      reject_d = 1'b0;
`ifdef DROP_DRAW_EN
      draw_d   = 1'b0;
`endif
    end

    // Outputs are registered, so they are derived from the upcoming state.
    wen_d       = (state_d == S_WRITE);
    waddr_d     = wen_d ? cell_addr(row_d, col_d) : waddr_q;
    wdata_d     = wen_d ? player_q + 1'b1 : wdata_q;
    chk_req_d   = (state_d == S_CHECK);
    chk_addr_d  = (chk_req_d && state_q == S_WRITE) ? waddr_q : chk_addr_q;
    busy_d      = (state_d == S_WRITE) || (state_d == S_CHECK) ||
                  (state_d == S_ADVANCE);
    game_over_d = (state_d == S_OVER);
  end

  // State, control and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      enter_q     <= 1'b1;
      player_q    <= '0;
      winner_q    <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      chk_req_q   <= 1'b0;
      chk_addr_q  <= '0;
      reject_q    <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enter_q     <= enter;
      player_q    <= player_d;
      winner_q    <= winner_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      chk_req_q   <= chk_req_d;
      chk_addr_q  <= chk_addr_d;
      reject_q    <= reject_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  // Latched drop target; only meaningful while a drop is in flight.
  always_ff @(posedge clk) begin
    col_q <= col_d;
    row_q <= row_d;
  end

  // Column heights grow by one on each board write; new_game wins over a write.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!rst || new_game) begin
        height_q[c] <= '0;
      end else if (state_q == S_WRITE && col_q == CW'(c)) begin
        height_q[c] <= height_q[c] + 1'b1;
      end
    end
  end

`ifdef DROP_DRAW_EN
  // Move counter and draw flag for full-board detection.
  always_ff @(posedge clk) begin
    if (!rst || new_game) begin
      move_q <= '0;
      draw_q <= 1'b0;
    end else begin
      draw_q <= draw_d;
      if (state_q == S_WRITE) begin
        move_q <= move_q + 1'b1;
      end
    end
  end

  assign board_full = (move_q == MW'(CELLS));
  assign draw       = draw_q;
`else
  assign draw = 1'b0;
`endif

  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign chk_req   = chk_req_q;
  assign chk_addr  = chk_addr_q;
  assign player    = player_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;
  assign reject    = reject_q;
  assign busy      = busy_q;

endmodule
